// File: rtl/fixed_point_pkg.sv
// Shared op codes, FSM encoding and derived constants for the fixed-point engine.
package fixed_point_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        FPU_ADD  = 2'b00,
        FPU_SUB  = 2'b01,
        FPU_MUL  = 2'b10,
        FPU_SQRT = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_SQRT = 2'b10,
        ST_DONE = 2'b11
    } fpu_state_e;

    // One root bit per iteration; the radicand A*2^FBITS has WIDTH+FBITS bits.
    function automatic int unsigned sqrt_iter_count(input int unsigned width,
                                                    input int unsigned fbits);
        return (width + fbits) / 2;
    endfunction

    function automatic logic [63:0] sat_max_val(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_val(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_sqrt_iter.sv
// One restoring square-root step: brings down two radicand bits, decides one root bit.
module fixed_point_sqrt_iter #(
    parameter int unsigned ITER = 21
) (
    input  logic [ITER:0]       ac,
    input  logic [2*ITER-1:0]   x,
    input  logic [ITER-1:0]     q,
    output logic [ITER:0]       ac_next,
    output logic [2*ITER-1:0]   x_next,
    output logic [ITER-1:0]     q_next
);

    localparam int unsigned RW = ITER + 1;
    localparam int unsigned TW = RW + 2;

    logic [TW-1:0] ac_shift;
    logic [TW-1:0] trial;
    logic [TW-1:0] diff;
    logic          take;

    // The remainder never exceeds 2*root, so RW bits hold it in both outcomes.
    always_comb begin
        ac_shift = {ac, x[2*ITER-1 -: 2]};
        trial    = {1'b0, q, 2'b01};
        diff     = ac_shift - trial;
        take     = (ac_shift >= trial);
        ac_next  = take ? RW'(diff) : RW'(ac_shift);
        x_next   = {x[2*ITER-3:0], 2'b00};
        q_next   = {q[ITER-2:0], take};
    end

endmodule

// File: rtl/fixed_point_engine.sv
// Handshaked signed fixed-point ADD/SUB/MUL/SQRT unit with optional saturation.
module fixed_point_engine
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FBITS    = 10,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic             invalid
);

    localparam int unsigned ITER  = sqrt_iter_count(WIDTH, FBITS);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned RW    = ITER + 1;
    localparam int unsigned XW    = 2 * ITER;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] SAT_MAX     = WIDTH'(sat_max_val(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN     = WIDTH'(sat_min_val(WIDTH));
    localparam logic [PW-1:0]    MAG_POS_LIM = PW'(SAT_MAX);
    localparam logic [PW-1:0]    MAG_NEG_LIM = PW'(SAT_MIN);
    localparam logic [CNT_W-1:0] MUL_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] SQRT_LAST   = CNT_W'(ITER - 1);

    fpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [RW-1:0]    ac_q, ac_d;
    logic [XW-1:0]    x_q, x_d;
    logic [ITER-1:0]  root_q, root_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             overflow_q, overflow_d;
    logic             invalid_q, invalid_d;
    logic             op_ready_q, op_ready_d;

    logic [RW-1:0]    ac_nx;
    logic [XW-1:0]    x_nx;
    logic [ITER-1:0]  root_nx;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    prod_step;
    logic [PW-1:0]    scaled;
    logic             mul_ovf;
    logic [WIDTH-1:0] mul_wrap;

    fixed_point_sqrt_iter #(
        .ITER (ITER)
    ) u_sqrt_iter (
        .ac      (ac_q),
        .x       (x_q),
        .q       (root_q),
        .ac_next (ac_nx),
        .x_next  (x_nx),
        .q_next  (root_nx)
    );

    // Add/sub straight from the inputs so the result lands on the accepting edge.
    always_comb begin
        is_sub  = (operation == FPU_SUB);
        b_eff   = is_sub ? ~operand_2 : operand_2;
        sum     = operand_1 + b_eff + WIDTH'(is_sub);
        add_ovf = (operand_1[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != operand_1[WIDTH-1]);
        mag_a   = operand_1[WIDTH-1] ? -operand_1 : operand_1;
        mag_b   = operand_2[WIDTH-1] ? -operand_2 : operand_2;
    end

    // Shift-add step and final scaling; magnitude truncation rounds toward zero.
    always_comb begin
        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        scaled    = prod_step >> FBITS;
        mul_ovf   = neg_q ? (scaled > MAG_NEG_LIM) : (scaled > MAG_POS_LIM);
        mul_wrap  = neg_q ? -scaled[WIDTH-1:0] : scaled[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        ac_d       = ac_q;
        x_d        = x_q;
        root_d     = root_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    overflow_d = 1'b0;
                    invalid_d  = 1'b0;
                    cnt_d      = '0;
                    case (operation)
                        FPU_ADD, FPU_SUB: begin
                            overflow_d = add_ovf;
                            if (add_ovf && SATURATE) begin
                                result_d = operand_1[WIDTH-1] ? SAT_MIN : SAT_MAX;
                            end else begin
                                result_d = sum;
                            end
                            state_d = ST_DONE;
                        end
                        FPU_MUL: begin
                            mcand_d  = PW'(mag_a);
                            mplier_d = mag_b;
                            prod_d   = '0;
                            neg_d    = operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
                            state_d  = ST_MUL;
                        end
                        default: begin
                            if (operand_1[WIDTH-1]) begin
                                result_d  = '0;
                                invalid_d = 1'b1;
                                state_d   = ST_DONE;
                            end else begin
                                ac_d    = '0;
                                root_d  = '0;
                                x_d     = XW'(operand_1) << FBITS;
                                state_d = ST_SQRT;
                            end
                        end
                    endcase
                end
            end
            ST_MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == MUL_LAST) begin
                    overflow_d = mul_ovf;
                    if (mul_ovf && SATURATE) begin
                        result_d = neg_q ? SAT_MIN : SAT_MAX;
                    end else begin
                        result_d = mul_wrap;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_SQRT: begin
                ac_d   = ac_nx;
                x_d    = x_nx;
                root_d = root_nx;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == SQRT_LAST) begin
                    result_d = WIDTH'(root_nx);
                    state_d  = ST_DONE;
                end
            end
            default: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        result_valid_d = (state_d == ST_DONE);
        op_ready_d     = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            neg_q          <= 1'b0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            prod_q         <= '0;
            ac_q           <= '0;
            x_q            <= '0;
            root_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            invalid_q      <= 1'b0;
            op_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            neg_q          <= neg_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            prod_q         <= prod_d;
            ac_q           <= ac_d;
            x_q            <= x_d;
            root_q         <= root_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            invalid_q      <= invalid_d;
            op_ready_q     <= op_ready_d;
        end
    end

    assign op_ready     = op_ready_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign invalid      = invalid_q;

endmodule

// File: tb/tb_fixed_point_engine.sv
// Table-driven scoreboard bench: saturating and wrapping engines run in lock-step.
module tb_fixed_point_engine;
    import fixed_point_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res_sat;
        logic [31:0] res_wrap;
        logic        ovf;
        logic        inv;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  operation = 2'b00;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        result_ready = 1'b0;

    logic        op_ready, result_valid, overflow, invalid;
    logic [31:0] result;
    logic        op_ready_w, result_valid_w, overflow_w, invalid_w;
    logic [31:0] result_w;

    int tests = 0;
    int failed = 0;
    vec_t exp_q[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    fixed_point_engine #(.WIDTH(32), .FBITS(10), .SATURATE(1'b1)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .operation(operation), .operand_1(operand_1), .operand_2(operand_2),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .overflow(overflow), .invalid(invalid)
    );

    fixed_point_engine #(.WIDTH(32), .FBITS(10), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready_w),
        .operation(operation), .operand_1(operand_1), .operand_2(operand_2),
        .result(result_w), .result_valid(result_valid_w), .result_ready(result_ready),
        .overflow(overflow_w), .invalid(invalid_w)
    );

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] rs, input logic [31:0] rw,
                                input logic ovf, input logic inv, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res_sat = rs; v.res_wrap = rw;
        v.ovf = ovf; v.inv = inv; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clk);
        while (!op_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("op_ready_before_send", 64'(op_ready), 64'd1);
        op_valid  = 1'b1;
        operation = op;
        operand_1 = a;
        operand_2 = b;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        operation = 2'($urandom());
        operand_1 = $urandom();
        operand_2 = $urandom();
    endtask

    // Counts cycles from the accepting edge; 1 means visible right after it.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!result_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   lat;
        vec_t e;
        exp_q.push_back(v);
        send(v.op, v.a, v.b);
        wait_result(lat);
        check({tag, "_valid"}, 64'(result_valid), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
            check({tag, "_result"}, 64'(result), 64'(e.res_sat));
            check({tag, "_overflow"}, 64'(overflow), 64'(e.ovf));
            check({tag, "_invalid"}, 64'(invalid), 64'(e.inv));
            check({tag, "_wrap_valid"}, 64'(result_valid_w), 64'd1);
            check({tag, "_wrap_result"}, 64'(result_w), 64'(e.res_wrap));
            check({tag, "_wrap_overflow"}, 64'(overflow_w), 64'(e.ovf));
        end
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(FPU_ADD,  32'h0000_0600, 32'h0000_0900, 32'h0000_0F00, 32'h0000_0F00, 1'b0, 1'b0, 1);
        vecs[1]  = mk(FPU_MUL,  32'hFFFF_FA00, 32'h0000_0900, 32'hFFFF_F280, 32'hFFFF_F280, 1'b0, 1'b0, 33);
        vecs[2]  = mk(FPU_SQRT, 32'h0000_1000, 32'h0,         32'h0000_0800, 32'h0000_0800, 1'b0, 1'b0, 22);
        vecs[3]  = mk(FPU_SQRT, 32'hFFFF_FC00, 32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 1);
        vecs[4]  = mk(FPU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1);
        vecs[5]  = mk(FPU_MUL,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFC0_0000, 1'b1, 1'b0, 33);
        vecs[6]  = mk(FPU_SUB,  32'h0000_0400, 32'h0000_0800, 32'hFFFF_FC00, 32'hFFFF_FC00, 1'b0, 1'b0, 1);
        vecs[7]  = mk(FPU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        vecs[8]  = mk(FPU_MUL,  32'h8000_0000, 32'h0000_0400, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33);
        vecs[9]  = mk(FPU_MUL,  32'h8000_0000, 32'hFFFF_FC00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 33);
        vecs[10] = mk(FPU_SQRT, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 22);
        vecs[11] = mk(FPU_SQRT, 32'h7FFF_FFFF, 32'h0,         32'h0016_A09E, 32'h0016_A09E, 1'b0, 1'b0, 22);
        vecs[12] = mk(FPU_SQRT, 32'h0000_0800, 32'h0,         32'h0000_05A8, 32'h0000_05A8, 1'b0, 1'b0, 22);
        vecs[13] = mk(FPU_MUL,  32'hFFFF_FFFF, 32'h0000_0005, 32'h0,         32'h0,         1'b0, 1'b0, 33);
        vecs[14] = mk(FPU_ADD,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 32'h7FFF_FFFE, 1'b0, 1'b0, 1);
        vecs[15] = mk(FPU_MUL,  32'hFFFF_FC00, 32'hFFFF_F800, 32'h0000_0800, 32'h0000_0800, 1'b0, 1'b0, 33);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_result", 64'(result), 64'd0);
        check("reset_valid", 64'(result_valid), 64'd0);
        check("reset_op_ready", 64'(op_ready), 64'd1);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_invalid", 64'(invalid), 64'd0);

        // Result must hold while the consumer stalls.
        send(FPU_ADD, 32'h600, 32'h900);
        check("hold_first_valid", 64'(result_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", 64'(result), 64'h0F00);
            check("hold_valid", 64'(result_valid), 64'd1);
            check("hold_op_ready", 64'(op_ready), 64'd0);
            check("hold_overflow", 64'(overflow), 64'd0);
        end
        consume();

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a multiply aborts it.
        send(FPU_MUL, 32'h400, 32'h400);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_mul_not_done", 64'(result_valid), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_valid", 64'(result_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_op_ready", 64'(op_ready), 64'd1);
        check("abort_wrap_result", 64'(result_w), 64'd0);
        run_vec(mk(FPU_ADD, 32'd1, 32'd2, 32'd3, 32'd3, 1'b0, 1'b0, 1), "after_abort");

        // Consumer ready as soon as the result appears.
        result_ready = 1'b1;
        send(FPU_ADD, 32'd5, 32'd6);
        check("b2b_valid", 64'(result_valid), 64'd1);
        check("b2b_result", 64'(result), 64'd11);
        check("b2b_op_ready_in_done", 64'(op_ready), 64'd0);
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("b2b_valid_dropped", 64'(result_valid), 64'd0);
        check("b2b_op_ready_back", 64'(op_ready), 64'd1);
        run_vec(mk(FPU_SUB, 32'h400, 32'h800, 32'hFFFF_FC00, 32'hFFFF_FC00, 1'b0, 1'b0, 1), "b2b_sub");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fixed_point_engine.md
Name: fixed_point_engine

Overview:
Parametrised, handshaked fixed-point arithmetic unit in signed two's-complement Q(WIDTH-FBITS).FBITS format. It is the next generation of the core's fixed-point unit.
- Adds valid/ready handshakes on both the operation and result sides.
- Supports configurable width and fraction bits, signed operands, and a saturation mode with overflow and invalid flags.
- A synchronous reset aborts any operation in flight.
- Sits in the execute stage beside the integer ALU; the pipeline stalls on op_ready and result_valid.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be in 8..64.
- FBITS, 10: fraction bits. Must satisfy 0 <= FBITS < WIDTH, and WIDTH+FBITS must be even.
- SATURATE, 1: 1 clamps on overflow; 0 wraps (keeps the low bits).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  request present.
- op_ready  out  1  unit idle; a request is accepted when op_valid && op_ready.
- operation  in  2  FPU_ADD=00, FPU_SUB=01, FPU_MUL=10, FPU_SQRT=11.
- operand_1  in  WIDTH  signed fixed-point operand A (the only operand for SQRT).
- operand_2  in  WIDTH  signed fixed-point operand B (ignored for SQRT).
- result  out  WIDTH  signed fixed-point result; registered; stable while result_valid is high.
- result_valid  out  1  result available; held until consumed.
- result_ready  in  1  consumer takes the result when result_valid && result_ready.
- overflow  out  1  result exceeded range (clamped or wrapped); qualified by result_valid.
- invalid  out  1  SQRT of a negative operand; qualified by result_valid.

Behaviour:
- Reset (synchronous, wins over everything, including mid-operation): state=IDLE; result=0; result_valid=0; overflow=0; invalid=0; op_ready=1 after the reset edge; the iteration counter and datapath registers are cleared.
- FSM states:
  - IDLE:
    - op_ready=1.
    - On accept, operands and operation are latched.
    - ADD/SUB go to DONE.
    - MUL goes to MUL.
    - SQRT goes to DONE directly if the operand is negative; otherwise to SQRT.
  - MUL: radix-2 shift-add on operand magnitudes, 2*WIDTH-bit accumulator, one bit per cycle. Runs exactly WIDTH cycles, then goes to DONE.
  - SQRT: restoring digit-by-digit square root, one result bit per cycle. Runs ITER=(WIDTH+FBITS)/2 cycles, then goes to DONE.
  - DONE:
    - result_valid=1.
    - result, overflow and invalid are written on entry to DONE.
    - Leaves to IDLE on result_ready.
    - A new request is never accepted in the same cycle as DONE->IDLE (op_ready=0 in DONE).
- Latency (accepting edge = E0), result_valid high after:
  - ADD/SUB: E0+1.
  - MUL: E0+WIDTH+1.
  - SQRT: E0+ITER+1.
  - SQRT of a negative operand: E0+1.
- Inputs are don't-care except in IDLE; latched operands are unaffected by later input changes.
- ADD/SUB:
  - Full-width two's-complement sum or difference.
  - Overflow when the operand signs (B inverted for SUB) match and the result sign differs.
- MUL:
  - Result sign = sign(A) XOR sign(B).
  - Magnitude product P of 2*WIDTH bits; scaled value = P >> FBITS (truncates the magnitude, i.e. rounds toward zero), then sign is applied.
  - Overflow when the scaled magnitude exceeds 2^(WIDTH-1)-1 for a positive result, or 2^(WIDTH-1) for a negative result.
  - The most negative operand (0x80..0) is handled correctly via a WIDTH-bit unsigned magnitude.
- SQRT:
  - Result = floor(sqrt(A * 2^FBITS)); always non-negative; overflow=0.
  - A < 0: result=0, invalid=1.
  - A = 0: result=0, invalid=0.
- Saturation:
  - SATURATE=1: positive overflow gives 0x7F..F; negative overflow gives 0x80..0.
  - SATURATE=0: result is the low WIDTH bits of the exact value.
  - overflow is flagged in both modes.
- Flags: overflow and invalid are cleared on every accept, and are valid only while result_valid is high.
- Result hold: result and flags are held unchanged in DONE indefinitely while result_ready=0.

Decomposition:
- Package fixed_point_pkg holds:
  - FPU_* op codes;
  - FSM state encoding (IDLE, MUL, SQRT, DONE);
  - the ITER derivation;
  - saturation max/min constants as functions of WIDTH.
- Sub-module fixed_point_sqrt_iter holds one restoring-sqrt iteration step (combinational: ac, x, q -> ac_next, x_next, q_next). The FSM, counter and multiplier stay in the top level.

Test Plan (WIDTH=32, FBITS=10, SATURATE=1 unless stated):
- ADD 1536 (1.5) + 2304 (2.25) -> result 3840 at E0+1, overflow=0; hold result_ready=0 for 5 cycles -> result and result_valid stable, op_ready=0.
- MUL 0xFFFFFA00 (-1.5) * 2304 (2.25) -> 0xFFFFF280 (-3.375) at exactly E0+33, overflow=0.
- SQRT 4096 (4.0) -> 2048 at E0+22; SQRT 0xFFFFFC00 (-1.0) -> 0, invalid=1 at E0+1.
- ADD 0x7FFFFFFF + 1 -> 0x7FFFFFFF, overflow=1. With SATURATE=0 -> 0x80000000, overflow=1. MUL 0x7FFFFFFF * 0x7FFFFFFF -> 0x7FFFFFFF, overflow=1.
- Assert reset at cycle 10 of a MUL -> next cycle state IDLE, result_valid=0, result=0, op_ready=1; a following ADD 1+2 -> 3.
- Back-to-back: assert result_ready in the same cycle result_valid rises -> op_ready returns next cycle; the next SUB 1024-2048 -> 0xFFFFFC00.
